// File: rtl/gpu_axil_pkg.sv
// Shared definitions for the GPU command AXI4-Lite initiator: state encodings,
// slave register offsets and response codes.
package gpu_axil_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;
  localparam logic [2:0] ST_GAP     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_RD_ADDR = ST_RD_ADDR,
    S_RD_DATA = ST_RD_DATA,
    S_WR_REQ  = ST_WR_REQ,
    S_WR_RESP = ST_WR_RESP,
    S_GAP     = ST_GAP
  } state_e;

  localparam logic [31:0] FILL_OFFSET  = 32'h0000_000C;
  localparam logic [31:0] INSTR_OFFSET = 32'h0000_0010;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int unsigned BUF_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/gpu_cmd_axil_master.sv
// Pushes 32-bit GPU instructions over AXI4-Lite, polling the slave's fill
// register for credits so the GPU instruction buffer is never overrun.
module gpu_cmd_axil_master
  import gpu_axil_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           BUF_DEPTH  = BUF_DEPTH_DEFAULT,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           POLL_GAP   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  input  logic [31:0]           cmd_data,
  output logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [31:0]           sent_count,
  output logic                  resp_err
);

  localparam logic [ADDR_WIDTH-1:0] FILL_ADDR  = BASE_ADDR + ADDR_WIDTH'(FILL_OFFSET);
  localparam logic [ADDR_WIDTH-1:0] INSTR_ADDR = BASE_ADDR + ADDR_WIDTH'(INSTR_OFFSET);

  state_e      state_q, state_d;
  logic [4:0]  credits_q, credits_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] sent_q, sent_d;
  logic [31:0] gap_q, gap_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        err_q, err_d;

  logic [31:0] fill_w;
  logic        unused_rdata;

  assign fill_w       = {27'd0, m_axi_rdata[4:0]};
  assign unused_rdata = ^m_axi_rdata[31:5];

  always_comb begin
    state_d   = state_q;
    credits_d = credits_q;
    instr_d   = instr_q;
    sent_d    = sent_q;
    gap_d     = gap_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (credits_q != '0) begin
            instr_d = cmd_data;
            state_d = S_WR_REQ;
          end else begin
            state_d = S_RD_ADDR;
          end
        end
      end
      S_RD_ADDR: begin
        if (m_axi_arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (m_axi_rvalid) begin
          credits_d = (fill_w >= BUF_DEPTH) ? '0 : 5'(BUF_DEPTH - fill_w);
          if (m_axi_rresp != RESP_OKAY) err_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WR_REQ: begin
        aw_done_d = aw_done_q | m_axi_awready;
        w_done_d  = w_done_q | m_axi_wready;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        // Error responses still count as completed pushes into the GPU buffer.
        if (m_axi_bvalid) begin
          credits_d = credits_q - 5'd1;
          sent_d    = sent_q + 32'd1;
          if (m_axi_bresp != RESP_OKAY) err_d = 1'b1;
          gap_d     = '0;
          state_d   = (POLL_GAP == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        gap_d = gap_q + 32'd1;
        if (gap_d >= POLL_GAP) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      credits_q <= '0;
      instr_q   <= '0;
      sent_q    <= '0;
      gap_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      instr_q   <= instr_d;
      sent_q    <= sent_d;
      gap_q     <= gap_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
    end
  end

  // All channel outputs decode registered state only; nothing passes through
  // from the AXI inputs.
  assign cmd_ready     = (state_q == S_IDLE) && (credits_q != '0);
  assign m_axi_awvalid = (state_q == S_WR_REQ) && !aw_done_q;
  assign m_axi_awaddr  = (state_q == S_WR_REQ) ? INSTR_ADDR : '0;
  assign m_axi_awprot  = '0;
  assign m_axi_wvalid  = (state_q == S_WR_REQ) && !w_done_q;
  assign m_axi_wdata   = instr_q;
  assign m_axi_wstrb   = (state_q == S_WR_REQ) ? 4'hF : 4'h0;
  assign m_axi_bready  = (state_q == S_WR_RESP);
  assign m_axi_arvalid = (state_q == S_RD_ADDR);
  assign m_axi_araddr  = (state_q == S_RD_ADDR) ? FILL_ADDR : '0;
  assign m_axi_arprot  = '0;
  assign m_axi_rready  = (state_q == S_RD_DATA);
  assign sent_count    = sent_q;
  assign resp_err      = err_q;

endmodule

// File: tb/tb_gpu_cmd_axil_master.sv
// Bench for gpu_cmd_axil_master: a GPU-slave model with a fill counter, a
// command source, and a scoreboard of expected instruction writes.
module tb_gpu_cmd_axil_master;

  localparam int AW       = 16;
  localparam int DEPTH    = 16;
  localparam int GAP      = 2;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, sent_count;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        resp_err;

  gpu_cmd_axil_master #(
    .ADDR_WIDTH(AW),
    .BUF_DEPTH (DEPTH),
    .BASE_ADDR ('0),
    .POLL_GAP  (GAP)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .sent_count(sent_count), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [31:0] cmd_src[$];
  logic [31:0] exp_q[$];

  int aw_delay = 0, w_delay = 0, err_on = 0;
  int fill = 0, mcred = 0;
  int rd_count = 0, wr_count = 0, ind_n = 0;
  logic ovr_en = 1'b0;
  logic [4:0] ovr_val = '0;

  int aw_cnt, w_cnt, gap_n;
  logic aw_got, w_got, ar_phase, gap_chk, aw_chk;
  logic [AW-1:0] aw_addr_c;
  logic [31:0] wdata_c, junk;
  logic [3:0] wstrb_c;
  logic [4:0] fv;

  // Slave and command-source model: reacts on the falling edge, so the DUT's
  // outputs are stable and its inputs are settled before the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      cmd_valid = 0; cmd_data = '0;
      awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
      arready = 0; rvalid = 0; rdata = '0; rresp = 2'b00;
      aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; ar_phase = 0;
      gap_chk = 0; gap_n = 0; aw_chk = 0;
      cmd_src.delete(); exp_q.delete();
      fill = 0; mcred = 0; rd_count = 0; wr_count = 0; ind_n = 0;
    end else begin
      if (aw_chk) begin
        check("accept_to_awvalid", awvalid, 1);
        check("accept_to_wvalid", wvalid, 1);
        aw_chk = 0;
      end
      cmd_valid = (cmd_src.size() != 0);
      cmd_data  = cmd_valid ? cmd_src[0] : '0;
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(cmd_src.pop_front());
        aw_chk = 1;
      end

      arready = 0; rvalid = 0;
      if (ar_phase) begin
        check("rready", rready, 1);
        junk   = $urandom;
        fv     = ovr_en ? ovr_val : 5'(fill);
        rdata  = {junk[31:5], fv};
        rresp  = 2'b00;
        rvalid = 1;
        mcred  = (int'(fv) >= DEPTH) ? 0 : DEPTH - int'(fv);
        ar_phase = 0;
      end else if (arvalid) begin
        check("araddr", 32'(araddr), 32'h0C);
        arready  = 1;
        ar_phase = 1;
        rd_count++;
      end

      if (gap_chk) begin
        gap_n++;
        if (gap_n <= GAP) check("gap_cmd_ready_low", cmd_ready, 0);
        else begin
          check("gap_cmd_ready", cmd_ready, 32'(mcred != 0));
          gap_chk = 0;
        end
      end

      awready = 0; wready = 0; bvalid = 0;
      if (aw_got && w_got) begin
        check("bready", bready, 1);
        bvalid = 1;
        bresp  = (wr_count + 1 == err_on) ? 2'b10 : 2'b00;
        wr_count++;
        check("awaddr", 32'(aw_addr_c), 32'h10);
        check("wstrb", 32'(wstrb_c), 32'hF);
        if (exp_q.size() != 0) check("wdata", wdata_c, exp_q.pop_front());
        else check("write_expected", 0, 1);
        fill++; mcred--;
        aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
        gap_chk = 1; gap_n = 0;
      end else begin
        if (aw_got && !w_got) begin
          check("awvalid_dropped", awvalid, 0);
          check("wvalid_held", wvalid, 1);
          ind_n++;
        end
        if (awvalid && !aw_got) begin
          if (aw_cnt == aw_delay) begin
            awready = 1; aw_got = 1; aw_addr_c = awaddr;
          end else aw_cnt++;
        end
        if (wvalid && !w_got) begin
          if (w_cnt == w_delay) begin
            wready = 1; w_got = 1; wdata_c = wdata; wstrb_c = wstrb;
          end else w_cnt++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    reset = 1;
    tick(3);
    reset = 0;
    tick(1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while ((cmd_src.size() != 0 || exp_q.size() != 0) && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, 32'(cmd_src.size() == 0 && exp_q.size() == 0), 1);
    tick(6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int k;
    reset = 1; cmd_valid = 0; cmd_data = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0;
    tick(3);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_bready", bready, 0);
    check("rst_sent", sent_count, 0);
    check("rst_err", resp_err, 0);
    check("rst_awaddr", 32'(awaddr), 0);
    check("rst_araddr", 32'(araddr), 0);
    check("rst_wdata", wdata, 0);
    check("rst_wstrb", 32'(wstrb), 0);
    reset = 0;
    tick(1);

    // Single command from empty: one poll then one write.
    cmd_src.push_back(32'hA000_0001);
    wait_done("t1_done", 100);
    check("t1_reads", rd_count, 1);
    check("t1_writes", wr_count, 1);
    check("t1_sent", sent_count, 1);
    check("t1_err", resp_err, 0);

    // Back-to-back burst against a buffer that does not drain.
    do_reset();
    for (int i = 0; i < 20; i++) cmd_src.push_back(32'hC000_0000 + 32'(i));
    tick(250);
    check("t2_writes16", wr_count, 16);
    check("t2_sent16", sent_count, 16);
    check("t2_pending", cmd_src.size(), 4);
    check("t2_repoll", 32'(rd_count >= 3), 1);
    check("t2_cmd_ready", cmd_ready, 0);
    fill = fill - 4;
    wait_done("t2_done", 300);
    check("t2_writes20", wr_count, 20);
    check("t2_sent20", sent_count, 20);
    r0 = rd_count;
    tick(30);
    check("t2_no_idle_reads", rd_count, r0);

    // AWREADY well ahead of WREADY.
    do_reset();
    aw_delay = 0; w_delay = 3;
    cmd_src.push_back(32'h1234_5678);
    wait_done("t3_done", 100);
    check("t3_indep_cycles", ind_n, 3);
    check("t3_writes", wr_count, 1);
    check("t3_sent", sent_count, 1);
    w_delay = 0;

    // SLVERR on the second write is sticky but still counted.
    do_reset();
    err_on = 2;
    cmd_src.push_back(32'hBEEF_0001);
    wait_done("t4_done1", 100);
    check("t4_err_after1", resp_err, 0);
    cmd_src.push_back(32'hBEEF_0002);
    wait_done("t4_done2", 100);
    check("t4_err_after2", resp_err, 1);
    check("t4_sent2", sent_count, 2);
    cmd_src.push_back(32'hBEEF_0003);
    wait_done("t4_done3", 100);
    check("t4_err_sticky", resp_err, 1);
    check("t4_sent3", sent_count, 3);
    err_on = 0;

    // Reset while the write request is outstanding.
    do_reset();
    w_delay = 20;
    cmd_src.push_back(32'hDEAD_0001);
    k = 0;
    while (!awvalid && k < 40) begin
      tick(1);
      k++;
    end
    check("t5_in_wr_req", awvalid, 1);
    reset = 1;
    tick(1);
    check("t5_awvalid", awvalid, 0);
    check("t5_wvalid", wvalid, 0);
    check("t5_arvalid", arvalid, 0);
    check("t5_bready", bready, 0);
    check("t5_rready", rready, 0);
    check("t5_sent", sent_count, 0);
    check("t5_cmd_ready", cmd_ready, 0);
    check("t5_err", resp_err, 0);
    reset = 0;
    w_delay = 0;
    tick(20);
    check("t5_not_retried", wr_count, 0);
    check("t5_no_reads", rd_count, 0);

    // Fill readback above depth yields no credits.
    do_reset();
    ovr_en = 1; ovr_val = 5'h1F;
    cmd_src.push_back(32'h5555_AAAA);
    tick(60);
    check("t6_no_write", wr_count, 0);
    check("t6_repoll", 32'(rd_count >= 2), 1);
    check("t6_cmd_ready", cmd_ready, 0);
    ovr_en = 0;
    wait_done("t6_done", 100);
    check("t6_write", wr_count, 1);
    check("t6_sent", sent_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gpu_cmd_axil_master.md
# gpu_cmd_axil_master

AXI4-Lite initiator that pushes 32-bit GPU instructions from a local valid/ready command stream into the GPU control slave's instruction register. It sits between the host-side command source and the GPU AXI4-Lite slave, polling the slave's buffer-fill register so that it never overruns the GPU instruction buffer. It holds one outstanding transaction at a time.

## Interface
- `ADDR_WIDTH`, default 16: AXI address width; matches the slave.
- `BUF_DEPTH`, default 16: capacity of the GPU instruction buffer, in entries.
- `BASE_ADDR`, default 0: slave base address; offsets below are added to it.
- `POLL_GAP`, default 2: idle cycles after each write response before the next read or write.

Ports (clock and reset first):
- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command word available.
- `cmd_data` in 32: instruction word.
- `cmd_ready` out 1: command accepted on `cmd_valid && cmd_ready`.
- `m_axi_awaddr` out ADDR_WIDTH, `m_axi_awprot` out 3 (tied 0), `m_axi_awvalid` out 1, `m_axi_awready` in 1: write address channel.
- `m_axi_wdata` out 32, `m_axi_wstrb` out 4, `m_axi_wvalid` out 1, `m_axi_wready` in 1: write data channel.
- `m_axi_bresp` in 2, `m_axi_bvalid` in 1, `m_axi_bready` out 1: write response channel.
- `m_axi_araddr` out ADDR_WIDTH, `m_axi_arprot` out 3 (tied 0), `m_axi_arvalid` out 1, `m_axi_arready` in 1: read address channel.
- `m_axi_rdata` in 32, `m_axi_rresp` in 2, `m_axi_rvalid` in 1, `m_axi_rready` out 1: read data channel.
- `sent_count` out 32: total instructions acknowledged; wraps modulo 2^32.
- `resp_err` out 1: sticky; set by any non-OKAY BRESP or RRESP.

## Operation
Register map offsets:
- 0x0C: buffer fill, read from bits [4:0].
- 0x10: instruction register, write only.

Internal state:
- `credits`, 5 bits; reset value 0.
- Latched instruction register.
- `aw_done` and `w_done` flags.
- Gap counter.

FSM states:
- **IDLE**
  - `cmd_ready = (credits != 0)`.
  - On accept: latch `cmd_data` and go to WR_REQ.
  - If `cmd_valid && credits == 0`: go to RD_ADDR.
- **RD_ADDR**
  - Drive `arvalid = 1`, `araddr = BASE_ADDR + 0x0C`.
  - On `arready`: go to RD_DATA.
- **RD_DATA**
  - Drive `rready = 1`.
  - On `rvalid`: `credits = (rdata[4:0] >= BUF_DEPTH) ? 0 : BUF_DEPTH - rdata[4:0]`, then go to IDLE.
  - Bits [31:5] of `rdata` are ignored.
- **WR_REQ**
  - Drive `awvalid` and `wvalid` asserted together.
  - `awaddr = BASE_ADDR + 0x10`, `wstrb = 4'hF`, `wdata` = latched word.
  - Each valid drops independently once its ready is seen (`aw_done` / `w_done`).
  - When both channels are done, clear the flags and go to WR_RESP.
- **WR_RESP**
  - Drive `bready = 1`. This state is entered before BVALID can rise, so BVALID lasts exactly one cycle; the GPU buffer counts BVALID cycles as pushes.
  - On `bvalid`: `credits -= 1`, `sent_count += 1`, go to GAP.
- **GAP**
  - Wait POLL_GAP cycles, then go to IDLE.
  - The gap covers the slave's one-cycle registered fill-status lag.

Boundary and arbitration rules:
- Credits are only decremented in WR_RESP, which requires a prior nonzero value, so they cannot underflow.
- A fill reading of BUF_DEPTH or more gives 0 credits. On the next `cmd_valid` the block re-polls; it loops poll → IDLE until credits are nonzero.
- With no `cmd_valid` the block stays in IDLE and issues no reads.
- A non-OKAY response still completes the transaction as normal: the write is counted and credits are decremented. It also sets `resp_err`.
- Reset mid-transaction: at the first `clk` edge with `reset` high, all outputs take their reset values. A latched, unacknowledged instruction is dropped.

## Timing
Reset values:
- All valids, readies and `cmd_ready` = 0.
- `sent_count` = 0, `resp_err` = 0, `credits` = 0.
- State = IDLE.
- `awaddr`, `araddr`, `wdata` = 0; `wstrb` = 0.

Latency and ordering:
- Command accept to `awvalid` high: 1 cycle.
- `bvalid` sampled to `cmd_ready` high again: POLL_GAP + 1 cycles.
- All handshakes are registered. No output depends combinationally on an AXI input, except `cmd_ready`, which depends on state and credits only.

## Structure
- Package `gpu_axil_pkg` holds:
  - The state enum.
  - `FILL_OFFSET` (0x0C) and `INSTR_OFFSET` (0x10).
  - `RESP_OKAY` (2'b00).
  - The `BUF_DEPTH` default.
- Single module; no sub-module.

## Test plan
- Reset, then a single command 0xA000_0001, with the slave returning fill 0: one read of 0x0C, then a write of 0xA000_0001 to 0x10 with WSTRB = F; `sent_count` = 1; BVALID high for exactly 1 cycle.
- 20 back-to-back commands, with the slave draining 0 entries and its fill tracking the writes: exactly 16 writes, then repeated polls; `cmd_ready` stays 0 until the fill drops. After the slave drains 4 entries, 4 more writes go out.
- Slave asserts AWREADY 3 cycles before WREADY: AWVALID drops after its handshake, WVALID holds, and exactly one B handshake follows.
- BRESP = 2'b10 on the 2nd write: `resp_err` = 1 and stays 1; `sent_count` still increments to 2.
- Reset asserted while in WR_REQ: the next cycle has all valids = 0, `sent_count` = 0, `credits` = 0; the dropped command is not retried.
- Fill readback of 0x1F: credits = 0 and no write is issued.
